// File: rtl/ped_request_if.sv
// ped_request bus bundle
// button/phase inputs and sequencer-facing outputs
interface ped_request_if;
  logic       btn_raw;
  logic       cycle_start;
  logic       ped_mode;
  logic       walk;
  logic       req_pending;
  logic       served;
  logic [7:0] press_cnt;

  modport master (
    output btn_raw,
    output cycle_start,
    input  ped_mode,
    input  walk,
    input  req_pending,
    input  served,
    input  press_cnt
  );

  modport slave (
    input  btn_raw,
    input  cycle_start,
    output ped_mode,
    output walk,
    output req_pending,
    output served,
    output press_cnt
  );
endinterface

// File: rtl/ped_request.sv
// ped_request: sync, debounce and latch a
// pedestrian request, serve it on phase starts
module ped_request #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_PHASES     = 1,
  parameter int COOLDOWN_PHASES = 2
) (
  input  logic          clk,
  input  logic          rst,
  ped_request_if.slave  bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int PMAX =
    (WALK_PHASES > COOLDOWN_PHASES) ?
    WALK_PHASES : COOLDOWN_PHASES;
  localparam int PW = $clog2(PMAX + 1);

  localparam logic [DW-1:0] DLAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] WLAST =
    PW'(WALK_PHASES - 1);
  localparam logic [PW-1:0] CLAST =
    PW'((COOLDOWN_PHASES > 0) ?
        COOLDOWN_PHASES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WALK,
    COOLDOWN
  } state_t;

  state_t        state;
  logic          s1, s2;
  logic          btn_db;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] phcnt;
  logic          defer;
  logic          walk_q;
  logic [7:0]    pcnt;
  logic          accept;
  logic          wend;
  logic          cend;

  assign accept = s2 & ~btn_db & (dcnt == DLAST);

  assign wend = (state == WALK) & bus.cycle_start &
                (phcnt == WLAST);

  assign cend = bus.cycle_start & (phcnt == CLAST);

  assign bus.ped_mode    = walk_q;
  assign bus.walk        = walk_q;
  assign bus.req_pending = (state == PENDING) | defer;
  assign bus.served      = wend & ~rst;
  assign bus.press_cnt   = pcnt;

  // two-flop synchroniser and level debouncer
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      btn_db <= 1'b0;
      dcnt   <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
      if (s2 == btn_db) begin
        dcnt <= '0;
      end else if (dcnt == DLAST) begin
        btn_db <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // saturating count of accepted presses
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (accept && pcnt != 8'hff) begin
      pcnt <= pcnt + 8'd1;
    end
  end

  // request / walk / cooldown sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      phcnt  <= '0;
      defer  <= 1'b0;
      walk_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) state <= PENDING;
        end
        PENDING: begin
          if (bus.cycle_start) begin
            state  <= WALK;
            phcnt  <= '0;
            walk_q <= 1'b1;
          end
        end
        WALK: begin
          if (wend) begin
            walk_q <= 1'b0;
            phcnt  <= '0;
            if (COOLDOWN_PHASES == 0) begin
              state <= defer ? PENDING : IDLE;
              defer <= 1'b0;
            end else begin
              state <= COOLDOWN;
            end
          end else if (bus.cycle_start) begin
            phcnt <= phcnt + 1'b1;
          end
        end
        COOLDOWN: begin
          if (cend) begin
            state <= (defer | accept) ?
                     PENDING : IDLE;
            defer <= 1'b0;
            phcnt <= '0;
          end else begin
            if (accept) defer <= 1'b1;
            if (bus.cycle_start)
              phcnt <= phcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
